// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the multicycle LEGv8 main control FSM and its consumers.
package legv8_ctrl_pkg;

  // Main FSM states; the numeric codes are visible on the debug state port.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_READ = 4'd4,
    ST_LOAD_WB  = 4'd5,
    ST_STORE    = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_CBZ      = 4'd9,
    ST_B        = 4'd10
  } state_t;

  // Instruction classes as seen by the control FSM.
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LDUR    = 3'd1,
    CLS_STUR    = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  // Full 11-bit opcodes.
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_NOR  = 11'b11101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Prefix-coded opcodes: CBZ uses 8 opcode bits, B uses 6.
  localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
  localparam logic [10:0] CBZ_MATCH = 11'b10110100000;
  localparam logic [10:0] B_MASK    = 11'b11111100000;
  localparam logic [10:0] B_MATCH   = 11'b00010100000;

  // alu_op encodings, shared with the ALU control decoder.
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

  // ALU B-operand select encodings.
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_BROFF = 2'b11;

  // True when the masked opcode bits equal the match pattern.
  function automatic logic op_prefix_match(input logic [10:0] op,
                                           input logic [10:0] mask,
                                           input logic [10:0] match);
    return (op & mask) == match;
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational classification of the 11-bit opcode field into FSM classes.
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  // Exact matches first, then the prefix-coded branches; anything else is illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND ||
        opcode == OP_ORR || opcode == OP_NOR)
      op_class = CLS_R;
    else if (opcode == OP_LDUR)
      op_class = CLS_LDUR;
    else if (opcode == OP_STUR)
      op_class = CLS_STUR;
    else if (op_prefix_match(opcode, CBZ_MASK, CBZ_MATCH))
      op_class = CLS_CBZ;
    else if (op_prefix_match(opcode, B_MASK, B_MATCH))
      op_class = CLS_B;
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath. Outputs are decoded from
// the state register; only the FETCH write enables look at mem_ready, and
// reg2loc looks at the opcode so operand reads are right from DECODE onward.
module legv8_multicycle_control
  import legv8_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic        pc_source,
  output logic        pc_en,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t    state_q, state_d;
  logic      illegal_q, illegal_d;
  op_class_t op_class;
  logic      pc_write, pc_write_cond;

  legv8_opcode_class u_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // Next-state and sticky illegal-flag logic.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (op_class)
          CLS_R:    state_d = ST_R_EXEC;
          CLS_LDUR: state_d = ST_MEM_ADDR;
          CLS_STUR: state_d = ST_MEM_ADDR;
          CLS_CBZ:  state_d = ST_CBZ;
          CLS_B:    state_d = ST_B;
          default: begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // The IR is not rewritten after FETCH, so the class is still valid here.
      ST_MEM_ADDR: state_d = (op_class == CLS_STUR) ? ST_STORE : ST_MEM_READ;
      ST_MEM_READ: if (mem_ready) state_d = ST_LOAD_WB;
      ST_LOAD_WB:  state_d = ST_FETCH;
      ST_STORE:    if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_CBZ:      state_d = ST_FETCH;
      ST_B:        state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State and illegal-flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode; every output defaults to 0 so IDLE (and reset) is quiet.
  always_comb begin
    alu_op        = ALU_OP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        // IR load and PC+4 happen only on the cycle memory delivers the word.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: alu_src_b = SRC_B_BROFF;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      // mem_write is held as a request for the whole stall.
      ST_STORE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_RTYPE;
      end
      ST_R_WB: reg_write = 1'b1;
      ST_CBZ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_PASS_B;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      ST_B: begin
        pc_write  = 1'b1;
        pc_source = 1'b1;
      end
      default: ;
    endcase
  end

  // reg2loc selects Rt as the second read register for STUR and CBZ; forced low in IDLE.
  always_comb begin
    reg2loc = (state_q != ST_IDLE) &&
              (op_class == CLS_STUR || op_class == CLS_CBZ);
  end

  assign pc_en   = pc_write | (pc_write_cond & zero);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed testbench for legv8_multicycle_control with hand-computed vectors.
module tb_legv8_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        mem_read, mem_write, i_or_d, ir_write;
  logic        reg_write, mem_to_reg, reg2loc, pc_source;
  logic        pc_en, illegal;
  logic [3:0]  state;

  int checks   = 0;
  int failures = 0;
  int ir_pulses;
  int pc_pulses;

  // Packed view: alu_op_srcA_srcB_{mr mw iod irw}_{rw m2r r2l pcs}_pcen
  logic [13:0] ctrl;
  assign ctrl = {alu_op, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
                 ir_write, reg_write, mem_to_reg, reg2loc, pc_source, pc_en};

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_MADDR = 4'd3, S_MREAD = 4'd4, S_LWB = 4'd5,
                         S_STORE = 4'd6, S_REXEC = 4'd7, S_RWB = 4'd8,
                         S_CBZ = 4'd9, S_B = 4'd10;

  always #5 clk = ~clk;

  legv8_multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .reg2loc    (reg2loc),
    .pc_source  (pc_source),
    .pc_en      (pc_en),
    .illegal    (illegal),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_st(input string tag, input logic [3:0] st, input logic [13:0] c);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(c));
  endtask

  initial begin
    reset = 1'b1; opcode = 11'b10001011000; zero = 1'b0; mem_ready = 1'b1;
    cyc(); cyc();
    chk_st("reset", S_IDLE, 14'b00_0_00_0000_0000_0);
    chk("reset.illegal", 32'(illegal), 32'd0);

    // Release reset just after a rising edge.
    @(posedge clk); #1 reset = 1'b0;
    cyc(); chk_st("rel.idle", S_IDLE, 14'b00_0_00_0000_0000_0);
    cyc(); chk_st("add.fetch", S_FETCH, 14'b00_0_01_1001_0000_1);
    cyc(); chk_st("add.decode", S_DECODE, 14'b00_0_11_0000_0000_0);
    cyc(); chk_st("add.rexec", S_REXEC, 14'b10_1_00_0000_0000_0);
    cyc(); chk_st("add.rwb", S_RWB, 14'b00_0_00_0000_1000_0);
    cyc();
    // LDUR with a 2-cycle MEM_READ stall.
    opcode = 11'b11111000010;
    chk_st("ldur.fetch", S_FETCH, 14'b00_0_01_1001_0000_1);
    cyc(); chk_st("ldur.decode", S_DECODE, 14'b00_0_11_0000_0000_0);
    cyc(); chk_st("ldur.maddr", S_MADDR, 14'b00_1_10_0000_0000_0);
    cyc(); mem_ready = 1'b0; #1;
    chk_st("ldur.mread0", S_MREAD, 14'b00_0_00_1010_0000_0);
    cyc(); chk_st("ldur.mread1", S_MREAD, 14'b00_0_00_1010_0000_0);
    cyc(); mem_ready = 1'b1; #1;
    chk_st("ldur.mread2", S_MREAD, 14'b00_0_00_1010_0000_0);
    cyc(); chk_st("ldur.lwb", S_LWB, 14'b00_0_00_0000_1100_0);
    cyc();
    // CBZ taken.
    opcode = 11'b10110100101; zero = 1'b1; #1;
    chk_st("cbz1.fetch", S_FETCH, 14'b00_0_01_1001_0010_1);
    cyc(); chk_st("cbz1.decode", S_DECODE, 14'b00_0_11_0000_0010_0);
    cyc(); chk_st("cbz1.cbz", S_CBZ, 14'b01_1_00_0000_0011_1);
    zero = 1'b0; #1;
    chk("cbz1.pc_en_follows_zero", 32'(pc_en), 32'd0);
    cyc();
    // CBZ not taken.
    chk_st("cbz0.fetch", S_FETCH, 14'b00_0_01_1001_0010_1);
    cyc(); chk_st("cbz0.decode", S_DECODE, 14'b00_0_11_0000_0010_0);
    cyc(); chk_st("cbz0.cbz", S_CBZ, 14'b01_1_00_0000_0011_0);
    cyc();
    // B with 3 stalled FETCH cycles; IR and PC must update exactly once.
    opcode = 11'b00010100000; mem_ready = 1'b0; #1;
    ir_pulses = 0; pc_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ready = 1'b1; #1; end
      chk("b.fetch.state", 32'(state), 32'(S_FETCH));
      chk("b.fetch.mem_read", 32'(mem_read), 32'd1);
      ir_pulses += int'(ir_write);
      pc_pulses += int'(pc_en);
      cyc();
    end
    chk("b.ir_pulses", 32'(ir_pulses), 32'd1);
    chk("b.pc_pulses", 32'(pc_pulses), 32'd1);
    chk_st("b.decode", S_DECODE, 14'b00_0_11_0000_0000_0);
    cyc(); chk_st("b.b", S_B, 14'b00_0_00_0000_0001_1);
    cyc();
    // Illegal opcode returns to FETCH and sets the sticky flag.
    opcode = 11'b11111111111; #1;
    chk_st("ill.fetch", S_FETCH, 14'b00_0_01_1001_0000_1);
    chk("ill.flag_before", 32'(illegal), 32'd0);
    cyc(); chk_st("ill.decode", S_DECODE, 14'b00_0_11_0000_0000_0);
    cyc(); chk("ill.back_to_fetch", 32'(state), 32'(S_FETCH));
    chk("ill.flag_set", 32'(illegal), 32'd1);
    // Following ADD runs normally, flag stays set.
    opcode = 11'b10001011000;
    cyc(); chk("ill.add.decode", 32'(state), 32'(S_DECODE));
    cyc(); chk_st("ill.add.rexec", S_REXEC, 14'b10_1_00_0000_0000_0);
    cyc(); chk_st("ill.add.rwb", S_RWB, 14'b00_0_00_0000_1000_0);
    chk("ill.flag_sticky", 32'(illegal), 32'd1);
    cyc();
    // STUR, then reset asynchronously while the store is stalled.
    opcode = 11'b11111000000; #1;
    chk_st("stur.fetch", S_FETCH, 14'b00_0_01_1001_0010_1);
    cyc(); chk_st("stur.decode", S_DECODE, 14'b00_0_11_0000_0010_0);
    cyc(); chk_st("stur.maddr", S_MADDR, 14'b00_1_10_0000_0010_0);
    cyc(); mem_ready = 1'b0; #1;
    chk_st("stur.store", S_STORE, 14'b00_0_00_0110_0010_0);
    reset = 1'b1; #1;
    chk("stur.rst.mem_write", 32'(mem_write), 32'd0);
    chk_st("stur.rst", S_IDLE, 14'b00_0_00_0000_0000_0);
    chk("stur.rst.illegal", 32'(illegal), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    cyc(); chk("rel2.idle", 32'(state), 32'(S_IDLE));
    cyc(); chk("rel2.fetch", 32'(state), 32'(S_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
